counter_4_bit: RTL and testbench
================================

// Module: counter_4_bit
//
// PURPOSE
//   Free-running 4-bit binary up-counter, incrementing once per rising clock edge.
//   Standalone utility block used as a tick/sequence source and as a simple
//   clock/reset sanity target in bring-up benches.
//   No enable, load or direction control: the counter always counts while out of reset.
//
// PARAMETERS
//   CNT_WIDTH   4   Counter width in bits. Fixed at 4 for this block; cnt is CNT_WIDTH wide.
//
// PORTS
//   clk      in   1   System clock. Single clock domain, rising-edge active.
//   reset_n  in   1   Reset, asynchronous, active-low.
//   cnt      out  4   Current count value, driven directly from a register (no comb path).
//
// BEHAVIOUR
//   - One clock (clk). Reset is asynchronous and active-low (reset_n).
//   - Reset:
//       - reset_n low forces cnt to 4'h0 immediately, without waiting for a clk edge.
//       - cnt stays at 0 for as long as reset_n is held low, across any number of clk edges.
//   - Release:
//       - The first rising clk edge after reset_n goes high gives cnt = 1.
//       - Rising edges of clk that occur while reset_n is low are ignored.
//   - Count:
//       - On every rising clk edge with reset_n high: cnt <= cnt + 1, modulo 16.
//   - Wrap-around:
//       - 4'hF -> 4'h0 on the next edge.
//       - No carry or terminal-count output; no saturation.
//   - Latency: cnt updates on the rising edge and is valid one clock-to-Q delay after it.
//   - Reset mid-count: asserting reset_n at any point, including mid-cycle, clears cnt to 0
//     at once. Counting resumes from 0 after release.
//   - Power-up: cnt is undefined until the first reset_n assertion. Every user must
//     apply reset before relying on cnt.
//   - Timing: fully synchronous datapath; only reset_n enters the flops asynchronously.
//     The reset release must meet recovery/removal timing with respect to clk.
//
// TESTING
//   Clock: 10 ns period, clk = 0 at t = 0, rising edges at 5, 15, 25, ... ns.
//   1. Async reset: reset_n low at t = 100 ns (between edges)
//        -> cnt = 0 before the 105 ns edge; still 0 after the 105 ns edge.
//   2. Release: reset_n high at t = 110 ns
//        -> cnt = 1 after the 115 ns edge, 2 after 125 ns, 3 after 135 ns.
//   3. Wrap: starting from cnt = 15, one rising edge -> cnt = 0; the next edge -> cnt = 1.
//   4. Long run: 100 rising edges after release (115 ns .. 1105 ns) -> cnt = 4 (100 mod 16).
//   5. Reset mid-count: with cnt = 9, pulse reset_n low for 3 ns between edges
//        -> cnt = 0 at once; the next edge after release -> cnt = 1.
//   6. Held reset: reset_n low across 5 rising edges -> cnt stays 0 throughout;
//        the first edge after release -> cnt = 1.

Source files
------------

// File: rtl/counter_4_bit.sv
// Free-running binary up-counter with asynchronous active-low reset.
// Wraps modulo 2**CNT_WIDTH; no enable, load, direction or terminal-count output.
module counter_4_bit #(
   parameter int unsigned CNT_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   output logic [CNT_WIDTH-1:0] cnt
);

   logic [CNT_WIDTH-1:0] cnt_d;
   logic [CNT_WIDTH-1:0] cnt_q;

   // Next count: increment, natural wrap from all-ones back to zero
   always_comb begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
   end

   // Count register; reset clears it immediately, independent of clk
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Output comes straight from the flops
   assign cnt = cnt_q;

endmodule

// File: tb/tb_counter_4_bit.sv
// Directed bench for counter_4_bit: async reset, release, long run, wrap,
// mid-cycle reset pulse and reset held across several clock edges.
module tb_counter_4_bit;

   localparam int unsigned CNT_WIDTH = 4;

   typedef struct {
      int unsigned          n_edges;
      logic [CNT_WIDTH-1:0] exp_cnt;
      string                name;
   } vec_t;

   logic                 clk;
   logic                 reset_n;
   logic [CNT_WIDTH-1:0] cnt;

   int unsigned checks = 0;
   int unsigned errors = 0;

   vec_t vecs[8];

   counter_4_bit #(.CNT_WIDTH(CNT_WIDTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .cnt     (cnt)
   );

   // 10 ns clock, low at t = 0, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare the DUT count against an expected value
   task automatic check(input string name, input logic [CNT_WIDTH-1:0] exp_cnt);
      checks++;
      if (cnt !== exp_cnt) begin
         errors++;
         $display("FAIL %s: cnt=%0h expected %0h at %0t", name, cnt, exp_cnt, $time);
      end
   endtask

   // Stimulus and checking
   initial begin
      // Counting phases after the first release (edges at 115, 125, 135, ..., then wrap)
      vecs[0] = '{1,  4'h1, "release_e1"};
      vecs[1] = '{1,  4'h2, "release_e2"};
      vecs[2] = '{1,  4'h3, "release_e3"};
      vecs[3] = '{97, 4'h4, "long_run_100"};
      vecs[4] = '{11, 4'hF, "reach_15"};
      vecs[5] = '{1,  4'h0, "wrap_to_0"};
      vecs[6] = '{1,  4'h1, "after_wrap_1"};
      vecs[7] = '{8,  4'h9, "reach_9"};

      reset_n = 1'b1;

      // Async reset asserted between edges at t = 100
      #100;
      reset_n = 1'b0;
      #1;
      check("async_reset_before_edge", 4'h0);
      @(posedge clk);
      #1;
      check("reset_across_edge", 4'h0);

      // Release at t = 110
      #4;
      reset_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         repeat (vecs[i].n_edges) @(posedge clk);
         #1;
         check(vecs[i].name, vecs[i].exp_cnt);
      end

      // 3 ns reset pulse between edges while cnt = 9
      #2;
      reset_n = 1'b0;
      #1;
      check("pulse_clears_at_once", 4'h0);
      #2;
      reset_n = 1'b1;
      #1;
      check("pulse_released_no_edge", 4'h0);
      @(posedge clk);
      #1;
      check("pulse_first_edge", 4'h1);
      @(posedge clk);
      #1;
      check("pulse_second_edge", 4'h2);

      // Reset held low across 5 rising edges
      #3;
      reset_n = 1'b0;
      #1;
      check("held_assert", 4'h0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("held_edge_%0d", i), 4'h0);
      end
      #3;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("held_first_edge", 4'h1);
      repeat (2) @(posedge clk);
      #1;
      check("held_third_edge", 4'h3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
